alu16_seq: RTL and testbench

ALU16_SEQ -- requirements
Module: alu16_seq

---
 rtl/alu16_seq.sv | 142 ++++++++++++++
 tb/tb_alu16_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu16_seq.sv
// Sequential 16-bit ALU: ADD16 / ADD SP,e8 / INC16 / DEC16 computed through an 8-bit
// adder in two passes (low byte, then high byte), with CPU-style flag results.
module alu16_seq #(
   parameter logic FAST_INCDEC = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op16,
   input  logic [15:0] a16,
   input  logic [15:0] b16,
   input  logic [3:0]  flags_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] res16,
   output logic [3:0]  flags_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [1:0] OP_ADD16 = 2'b00;
   localparam logic [1:0] OP_ADDSP = 2'b01;
   localparam logic [1:0] OP_INC16 = 2'b10;
   localparam logic [1:0] OP_DEC16 = 2'b11;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [3:0]  flags_lat_q, flags_lat_d;
   logic [15:0] res_q, res_d;
   logic [3:0]  flags_out_q, flags_out_d;
   logic        c7_q, c7_d;
   logic        c3_q, c3_d;

   logic [7:0]  b_lo, b_hi;
   logic        cin0;
   logic [8:0]  lo_sum, hi_sum;
   logic [4:0]  lo_nib, hi_nib;
   logic [15:0] incdec_full;
   logic        accept;

   // Operand selection from the latched request; DEC16 adds 0xFFFF as two's complement.
   always_comb begin
      b_lo = 8'h00;
      b_hi = 8'h00;
      cin0 = 1'b0;
      unique case (op_q)
         OP_ADD16: begin b_lo = b_q[7:0]; b_hi = b_q[15:8];   end
         OP_ADDSP: begin b_lo = b_q[7:0]; b_hi = {8{b_q[7]}}; end
         OP_INC16: begin cin0 = 1'b1;                         end
         OP_DEC16: begin b_lo = 8'hFF; b_hi = 8'hFF;          end
      endcase
   end

   assign lo_sum      = {1'b0, a_q[7:0]}  + {1'b0, b_lo}      + {8'h00, cin0};
   assign lo_nib      = {1'b0, a_q[3:0]}  + {1'b0, b_lo[3:0]} + {4'h0, cin0};
   assign hi_sum      = {1'b0, a_q[15:8]} + {1'b0, b_hi}      + {8'h00, c7_q};
   assign hi_nib      = {1'b0, a_q[11:8]} + {1'b0, b_hi[3:0]} + {4'h0, c7_q};
   assign incdec_full = op_q[0] ? (a_q - 16'd1) : (a_q + 16'd1);
   assign accept      = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      flags_lat_d = flags_lat_q;
      res_d       = res_q;
      flags_out_d = flags_out_q;
      c7_d        = c7_q;
      c3_d        = c3_q;

      if (accept) begin
         op_d        = op16;
         a_d         = a16;
         b_d         = b16;
         flags_lat_d = flags_in;
      end

      unique case (state_q)
         S_IDLE: if (accept) state_d = S_LO;
         S_LO: begin
            res_d[7:0] = lo_sum[7:0];
            c7_d       = lo_sum[8];
            c3_d       = lo_nib[4];
            if (FAST_INCDEC && op_q[1]) begin
               res_d       = incdec_full;
               flags_out_d = flags_lat_q;
               state_d     = S_DONE;
            end else begin
               state_d = S_HI;
            end
         end
         S_HI: begin
            res_d[15:8] = hi_sum[7:0];
            unique case (op_q)
               OP_ADD16: flags_out_d = {flags_lat_q[3], 1'b0, hi_nib[4], hi_sum[8]};
               OP_ADDSP: flags_out_d = {2'b00, c3_q, c7_q};
               default:  flags_out_d = flags_lat_q;
            endcase
            state_d = S_DONE;
         end
         S_DONE: state_d = accept ? S_LO : S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= 2'b00;
         a_q         <= 16'h0000;
         b_q         <= 16'h0000;
         flags_lat_q <= 4'b0000;
         res_q       <= 16'h0000;
         flags_out_q <= 4'b0000;
         c7_q        <= 1'b0;
         c3_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         flags_lat_q <= flags_lat_d;
         res_q       <= res_d;
         flags_out_q <= flags_out_d;
         c7_q        <= c7_d;
         c3_q        <= c3_d;
      end
   end

   assign busy      = (state_q == S_LO) || (state_q == S_HI);
   assign done      = (state_q == S_DONE);
   assign res16     = res_q;
   assign flags_out = flags_out_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Directed bench for alu16_seq: a vector table run on a normal and a FAST_INCDEC
// instance, plus hand sequences for back-to-back starts, ignored starts and reset abort.
module tb_alu16_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_s = 1'b0;
   logic        start_f = 1'b0;
   logic [1:0]  op16 = 2'b00;
   logic [15:0] a16 = 16'h0000;
   logic [15:0] b16 = 16'h0000;
   logic [3:0]  flags_in = 4'b0000;

   logic        busy_s, done_s, busy_f, done_f;
   logic [15:0] res_s, res_f;
   logic [3:0]  flg_s, flg_f;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   alu16_seq #(.FAST_INCDEC(1'b0)) dut (
      .clk(clk), .rst(rst), .start(start_s), .op16(op16), .a16(a16), .b16(b16),
      .flags_in(flags_in), .busy(busy_s), .done(done_s), .res16(res_s), .flags_out(flg_s)
   );

   alu16_seq #(.FAST_INCDEC(1'b1)) dut_f (
      .clk(clk), .rst(rst), .start(start_f), .op16(op16), .a16(a16), .b16(b16),
      .flags_in(flags_in), .busy(busy_f), .done(done_f), .res16(res_f), .flags_out(flg_f)
   );

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  f;
      logic [15:0] er;
      logic [3:0]  ef;
      logic        fast;
      int          lat;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  lat;
      bit  got;
      @(negedge clk);
      op16 = v.op; a16 = v.a; b16 = v.b; flags_in = v.f;
      if (v.fast) start_f = 1'b1; else start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0; start_f = 1'b0;
      a16 = ~v.a; b16 = ~v.b; flags_in = ~v.f;
      lat = 0; got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk); #1;
         lat++;
         got = v.fast ? done_f : done_s;
      end
      check($sformatf("vec%0d_latency", idx), lat, v.lat);
      if (got) begin
         check($sformatf("vec%0d_res16", idx), v.fast ? res_f : res_s, v.er);
         check($sformatf("vec%0d_flags", idx), v.fast ? flg_f : flg_s, v.ef);
      end
      $display("vec%0d op=%b a=%h b=%h f=%b -> res=%h flags=%b lat=%0d", idx, v.op, v.a, v.b,
               v.f, v.fast ? res_f : res_s, v.fast ? flg_f : flg_s, lat);
   endtask

   initial begin
      int exp_busy[6];
      int exp_done[6];
      int done_cnt;

      //            op     a         b         f       res       flags  fast  lat
      vecs[0]  = '{2'b00, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 1'b0, 2};
      vecs[1]  = '{2'b00, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, 1'b0, 2};
      vecs[2]  = '{2'b01, 16'h0005, 16'h00FE, 4'b1111, 16'h0003, 4'b0011, 1'b0, 2};
      vecs[3]  = '{2'b01, 16'hFFF8, 16'h0008, 4'b0000, 16'h0000, 4'b0011, 1'b0, 2};
      vecs[4]  = '{2'b11, 16'h0000, 16'h0000, 4'b0101, 16'hFFFF, 4'b0101, 1'b0, 2};
      vecs[5]  = '{2'b10, 16'hFFFF, 16'h1234, 4'b1010, 16'h0000, 4'b1010, 1'b0, 2};
      vecs[6]  = '{2'b00, 16'h1234, 16'h1111, 4'b0100, 16'h2345, 4'b0000, 1'b0, 2};
      vecs[7]  = '{2'b01, 16'h1000, 16'hAB80, 4'b1111, 16'h0F80, 4'b0000, 1'b0, 2};
      vecs[8]  = '{2'b11, 16'h0100, 16'h0000, 4'b0011, 16'h00FF, 4'b0011, 1'b0, 2};
      vecs[9]  = '{2'b00, 16'h8800, 16'h8800, 4'b0000, 16'h1000, 4'b0011, 1'b0, 2};
      vecs[10] = '{2'b11, 16'h0000, 16'h0000, 4'b0101, 16'hFFFF, 4'b0101, 1'b1, 1};
      vecs[11] = '{2'b10, 16'h00FF, 16'h0000, 4'b0000, 16'h0100, 4'b0000, 1'b1, 1};
      vecs[12] = '{2'b00, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 1'b1, 2};

      #1;
      check("reset_busy", {busy_s, busy_f}, 2'b00);
      check("reset_done", {done_s, done_f}, 2'b00);
      check("reset_res16", res_s, 16'h0000);
      check("reset_flags", flg_s, 4'b0000);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

      // start held high: LO, HI, DONE repeating with no idle bubble
      exp_busy = '{1, 1, 0, 1, 1, 0};
      exp_done = '{0, 0, 1, 0, 0, 1};
      @(negedge clk);
      op16 = 2'b00; a16 = 16'h0FFF; b16 = 16'h0001; flags_in = 4'b1000;
      start_s = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         check($sformatf("held_busy%0d", c), busy_s, exp_busy[c]);
         check($sformatf("held_done%0d", c), done_s, exp_done[c]);
         $display("held cycle %0d busy=%b done=%b", c, busy_s, done_s);
      end
      @(negedge clk);
      start_s = 1'b0;
      repeat (2) @(posedge clk);

      // start pulse during LO must be ignored: exactly one done
      @(negedge clk);
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      @(negedge clk);
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (done_s) done_cnt++;
      end
      check("ignored_start_done_count", done_cnt, 1);
      check("ignored_start_busy", busy_s, 1'b0);
      $display("ignored start: done pulses=%0d", done_cnt);

      // results hold through idle cycles
      check("hold_res16", res_s, 16'h1000);
      check("hold_flags", flg_s, 4'b1010);

      // async reset during HI of ADD16 aborts the operation
      @(negedge clk);
      op16 = 2'b00; a16 = 16'h1234; b16 = 16'h1111; flags_in = 4'b1111;
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      @(posedge clk); #1;
      check("abort_in_hi_busy", busy_s, 1'b1);
      check("abort_lo_byte", res_s[7:0], 8'h45);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", busy_s, 1'b0);
      check("abort_done", done_s, 1'b0);
      check("abort_res16", res_s, 16'h0000);
      check("abort_flags", flg_s, 4'b0000);
      $display("abort: busy=%b done=%b res=%h flags=%b", busy_s, done_s, res_s, flg_s);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (done_s) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);

      run_vec(vecs[6], 100);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
